// File: rtl/framebuffer_reader.sv
// Raster-order frame-buffer scan-out: Avalon-MM pipelined read master feeding an Avalon-ST source via a local FIFO.
// Define FRAMEBUFFER_READER_PACKET_EN to add st_startofpacket/st_endofpacket framing flags.
module framebuffer_reader #(
   parameter int MM_ADDR_WIDTH    = 32,
   parameter int MM_DATA_WIDTH    = 16,
   parameter int MM_START_ADDRESS = 0,
   parameter int WIDTH            = 640,
   parameter int HEIGHT           = 480,
   parameter int FIFO_DEPTH       = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     enable,
   output logic                     mm_read,
   output logic [MM_ADDR_WIDTH-1:0] mm_address,
   input  logic [MM_DATA_WIDTH-1:0] mm_readdata,
   input  logic                     mm_readdatavalid,
   input  logic                     mm_waitrequest,
   input  logic                     st_ready,
   output logic [MM_DATA_WIDTH-1:0] st_data,
   output logic                     st_valid
`ifdef FRAMEBUFFER_READER_PACKET_EN
   ,
   output logic                     st_startofpacket,
   output logic                     st_endofpacket
`endif
);

   // state   | meaning
   // S_IDLE  | stopped; enable starts a frame
   // S_FETCH | issuing raster-order reads under FIFO credit
   // S_DRAIN | last pixel issued, waiting for responses and FIFO to empty

   localparam int PW = $clog2(FIFO_DEPTH) + 1;
   localparam int FW = $clog2(FIFO_DEPTH);
   localparam int XW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
   localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

   localparam logic [MM_ADDR_WIDTH-1:0] ADDR_BASE  = MM_ADDR_WIDTH'(MM_START_ADDRESS);
   localparam logic [MM_ADDR_WIDTH-1:0] ADDR_STEP  = MM_ADDR_WIDTH'(MM_DATA_WIDTH / 8);
   localparam logic [XW-1:0]            X_LAST     = XW'(WIDTH - 1);
   localparam logic [YW-1:0]            Y_LAST     = YW'(HEIGHT - 1);
   localparam logic [PW:0]              CREDIT_MAX = (PW + 1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN} state_t;

   state_t                   state_q;
   logic                     read_q;
   logic [MM_ADDR_WIDTH-1:0] addr_q;
   logic [XW-1:0]            x_q;
   logic [YW-1:0]            y_q;
   logic [PW-1:0]            pending_q, pending_d;
   logic [PW-1:0]            count_q, count_d;
   logic [FW-1:0]            wr_ptr_q, rd_ptr_q;
   logic [MM_DATA_WIDTH-1:0] data_mem [FIFO_DEPTH];

   logic accept, push, pop, x_end, last_pix, credit_ok, fifo_nonempty;

   assign accept        = read_q & ~mm_waitrequest;
   assign push          = mm_readdatavalid;
   assign fifo_nonempty = (count_q != '0);
   assign pop           = fifo_nonempty & st_ready;
   assign x_end         = (x_q == X_LAST);
   assign last_pix      = x_end & (y_q == Y_LAST);

   assign pending_d = pending_q + PW'(accept) - PW'(push);
   assign count_d   = count_q + PW'(push) - PW'(pop);
   // Credit is judged on next-cycle occupancy so the registered mm_read never over-commits the FIFO.
   assign credit_ok = ({1'b0, pending_d} + {1'b0, count_d}) < CREDIT_MAX;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         read_q  <= 1'b0;
         addr_q  <= ADDR_BASE;
         x_q     <= '0;
         y_q     <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (enable) begin
                  state_q <= S_FETCH;
                  read_q  <= 1'b1;
               end
            end
            S_FETCH: begin
               if (accept) begin
                  if (last_pix) begin
                     x_q    <= '0;
                     y_q    <= '0;
                     addr_q <= ADDR_BASE;
                     if (enable) begin
                        read_q <= credit_ok;
                     end else begin
                        read_q  <= 1'b0;
                        state_q <= S_DRAIN;
                     end
                  end else begin
                     addr_q <= addr_q + ADDR_STEP;
                     if (x_end) begin
                        x_q <= '0;
                        y_q <= y_q + YW'(1);
                     end else begin
                        x_q <= x_q + XW'(1);
                     end
                     read_q <= credit_ok;
                  end
               end else if (!read_q) begin
                  read_q <= credit_ok;
               end
            end
            S_DRAIN: begin
               if (pending_q == '0 && count_q == '0) state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pending_q <= '0;
         count_q   <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
      end else begin
         pending_q <= pending_d;
         count_q   <= count_d;
         if (push) wr_ptr_q <= wr_ptr_q + FW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + FW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push) data_mem[wr_ptr_q] <= mm_readdata;
   end

   assign mm_read    = read_q;
   assign mm_address = addr_q;
   assign st_valid   = fifo_nonempty;
   assign st_data    = data_mem[rd_ptr_q];

`ifdef FRAMEBUFFER_READER_PACKET_EN
   // Responses return in order, so the slot reserved at issue time is the one the data later lands in.
   logic [FW-1:0] iss_ptr_q;
   logic [1:0]    flag_mem [FIFO_DEPTH];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         iss_ptr_q <= '0;
      end else if (accept) begin
         iss_ptr_q <= iss_ptr_q + FW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (accept) flag_mem[iss_ptr_q] <= {(x_q == '0) && (y_q == '0), last_pix};
   end

   assign st_startofpacket = fifo_nonempty & flag_mem[rd_ptr_q][1];
   assign st_endofpacket   = fifo_nonempty & flag_mem[rd_ptr_q][0];
`endif

endmodule

// File: tb/tb_framebuffer_reader.sv
// Scoreboard bench for framebuffer_reader on a 4x2 frame with a 4-entry FIFO and an in-order memory model.
module tb_framebuffer_reader;
   localparam int AW = 32, DW = 16, START = 1000, W = 4, H = 2, D = 4;
   localparam int LAST_ADDR = START + 2 * (W * H - 1);

   logic          clk = 1'b0;
   logic          reset, enable, mm_read, mm_readdatavalid, mm_waitrequest, st_ready, st_valid;
   logic [AW-1:0] mm_address;
   logic [DW-1:0] mm_readdata, st_data;
`ifdef FRAMEBUFFER_READER_PACKET_EN
   logic          st_startofpacket, st_endofpacket;
`endif

   always #5 clk = ~clk;

   framebuffer_reader #(
      .MM_ADDR_WIDTH(AW), .MM_DATA_WIDTH(DW), .MM_START_ADDRESS(START),
      .WIDTH(W), .HEIGHT(H), .FIFO_DEPTH(D)
   ) dut (
      .clk(clk), .reset(reset), .enable(enable),
      .mm_read(mm_read), .mm_address(mm_address), .mm_readdata(mm_readdata),
      .mm_readdatavalid(mm_readdatavalid), .mm_waitrequest(mm_waitrequest),
      .st_ready(st_ready), .st_data(st_data), .st_valid(st_valid)
`ifdef FRAMEBUFFER_READER_PACKET_EN
      , .st_startofpacket(st_startofpacket), .st_endofpacket(st_endofpacket)
`endif
   );

   int total = 0, bad = 0;
   int sb[$];
   int resp[$];
   int exp_addr, n_acc, n_pop, n_hold, cyc, wait_left, wait_addr;
   int first_acc, first_val, first_addr, last_pop, gaps, n_sop, n_eop;
   bit hold, en_v, rdy_v, track_gaps;

   task automatic chk(input string tag, input longint got, input longint exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic clear_model();
      sb.delete();
      resp.delete();
      exp_addr = START; n_acc = 0; n_pop = 0; n_hold = 0; cyc = 0;
      wait_left = 0; wait_addr = 0; first_acc = -1; first_val = -1; first_addr = -1;
      last_pop = -1; gaps = 0; n_sop = 0; n_eop = 0; track_gaps = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1; enable = 1'b0; mm_readdatavalid = 1'b0; mm_readdata = '0; mm_waitrequest = 1'b0;
      #1;
      chk("rst_mm_read", mm_read, 0);
      chk("rst_st_valid", st_valid, 0);
      chk("rst_mm_address", mm_address, START);
`ifdef FRAMEBUFFER_READER_PACKET_EN
      chk("rst_sop", st_startofpacket, 0);
      chk("rst_eop", st_endofpacket, 0);
`endif
      clear_model();
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic cycle();
      int exp_d;
      @(negedge clk);
      enable   = en_v;
      st_ready = rdy_v;
      if (!hold && resp.size() > 0) begin
         mm_readdatavalid = 1'b1;
         mm_readdata      = DW'(resp.pop_front());
      end else begin
         mm_readdatavalid = 1'b0;
         mm_readdata      = '0;
      end
      mm_waitrequest = 1'b0;
      if (mm_read && wait_left > 0 && mm_address == AW'(wait_addr)) begin
         mm_waitrequest = 1'b1;
         wait_left--;
      end
      #1;
      cyc++;
      if (mm_waitrequest) begin
         n_hold++;
         chk("hold_read", mm_read, 1);
         chk("hold_addr", mm_address, wait_addr);
      end
      if (mm_read && !mm_waitrequest) begin
         chk("addr", mm_address, exp_addr);
         if (first_addr < 0) first_addr = int'(mm_address);
         sb.push_back(exp_addr);
         resp.push_back(int'(mm_address));
         exp_addr = (exp_addr == LAST_ADDR) ? START : exp_addr + 2;
         if (first_acc < 0) first_acc = cyc;
         n_acc++;
      end
      if (st_valid && first_val < 0) first_val = cyc;
      if (track_gaps && first_val >= 0 && !st_valid) gaps++;
      if (st_valid && !st_ready && sb.size() > 0) chk("frozen_data", st_data, sb[0]);
      if (st_valid && st_ready) begin
         if (sb.size() > 0) exp_d = sb.pop_front();
         else exp_d = -1;
         chk("pop_data", st_data, exp_d);
`ifdef FRAMEBUFFER_READER_PACKET_EN
         chk("sop_flag", st_startofpacket, exp_d == START);
         chk("eop_flag", st_endofpacket, exp_d == LAST_ADDR);
         if (st_startofpacket) n_sop++;
         if (st_endofpacket) n_eop++;
`endif
         last_pop = int'(st_data);
         n_pop++;
      end
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   initial begin
      reset = 1'b1; enable = 1'b0; st_ready = 1'b0;
      mm_readdatavalid = 1'b0; mm_readdata = '0; mm_waitrequest = 1'b0;
      hold = 1'b0; en_v = 1'b0; rdy_v = 1'b1;
      clear_model();

      // streaming two frames with zero-wait memory
      do_reset();
      en_v = 1'b1; rdy_v = 1'b1;
      track_gaps = 1'b1;
      run(40);
      chk("t1_latency_ge2", (first_val - first_acc) >= 2, 1);
      chk("t1_no_gaps", gaps, 0);
      chk("t1_pops_ge16", n_pop >= 16, 1);

      // waitrequest stall on 1004
      do_reset();
      en_v = 1'b1; wait_addr = START + 4; wait_left = 3;
      run(20);
      chk("t2_hold_cycles", n_hold, 3);

      // sink back-pressure fills exactly FIFO_DEPTH credits
      do_reset();
      en_v = 1'b1; rdy_v = 1'b0;
      run(10);
      chk("t3_inflight", n_acc - n_pop, D);
      chk("t3_read_off", mm_read, 0);
      chk("t3_valid", st_valid, 1);
      rdy_v = 1'b1;
      run(20);
      en_v = 1'b0;
      run(40);
      chk("t3_sb_empty", sb.size(), 0);
      chk("t3_idle_read", mm_read, 0);

      // enable dropped mid-frame finishes the frame then drains
      do_reset();
      en_v = 1'b1;
      for (int i = 0; i < 10 && n_acc < 2; i++) cycle();
      chk("t4_reached_px2", n_acc, 2);
      en_v = 1'b0;
      run(40);
      chk("t4_acc", n_acc, W * H);
      chk("t4_pop", n_pop, W * H);
      chk("t4_last_data", last_pop, LAST_ADDR);
      chk("t4_read_off", mm_read, 0);
      chk("t4_valid_off", st_valid, 0);
      chk("t4_addr_base", mm_address, START);
      en_v = 1'b1;
      run(6);
      chk("t4_restart", n_acc > W * H, 1);

      // reset with two reads outstanding
      do_reset();
      en_v = 1'b1; hold = 1'b1;
      for (int i = 0; i < 20 && n_acc < 2; i++) cycle();
      chk("t5_two_pending", n_acc, 2);
      do_reset();
      hold = 1'b0; en_v = 1'b1;
      run(10);
      chk("t5_first_addr", first_addr, START);
      chk("t5_data_flow", n_pop > 0, 1);

`ifdef FRAMEBUFFER_READER_PACKET_EN
      // two framed packets
      do_reset();
      en_v = 1'b1;
      for (int i = 0; i < 40 && n_acc < W * H + 1; i++) cycle();
      en_v = 1'b0;
      run(40);
      chk("t6_pops", n_pop, 2 * W * H);
      chk("t6_sop_count", n_sop, 2);
      chk("t6_eop_count", n_eop, 2);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1);
   end
endmodule
